// File: rtl/hydra_tx_scheduler.sv
// hydra_tx_scheduler: shares the four Hydra UART transmitters between local
// FIFO packets and forwarded RX packets, loading all target ports at once.
module hydra_tx_scheduler #(
   parameter int WIDTH        = 64,
   parameter int MAX_STARVE   = 4,
   parameter int BUSY_TIMEOUT = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             fwd_valid,
   input  logic [WIDTH-2:0] fwd_data,
   input  logic             fwd_downstream,
   output logic             fwd_ack,
   input  logic             local_valid,
   input  logic [WIDTH-2:0] local_data,
   output logic             local_ack,
   input  logic [3:0]       enable_piso_upstream,
   input  logic [3:0]       enable_piso_downstream,
   input  logic [3:0]       tx_busy,
   output logic [3:0]       ld_tx_data_uart,
   output logic [WIDTH-2:0] tx_data,
   output logic             sched_busy,
   output logic [15:0]      drop_count,
   output logic [7:0]       timeout_count
);

   localparam int SW = $clog2(MAX_STARVE + 1);
   localparam int TW = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(MAX_STARVE);
   localparam logic [TW-1:0] TIMER_LIM  = TW'(BUSY_TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT_PORTS,
      S_LOAD,
      S_WAIT_BUSY
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       mask_q, mask_d;
   logic [WIDTH-2:0] data_q, data_d;
   logic             fwd_ack_q, fwd_ack_d;
   logic             local_ack_q, local_ack_d;
   logic [SW-1:0]    starve_q, starve_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [15:0]      drop_q, drop_d;
   logic [7:0]       tout_q, tout_d;

   logic             grant_fwd;
   logic             grant_local;
   logic [3:0]       grant_mask;

   // Arbitrate in IDLE; a cycle carrying an ack is skipped so the acked
   // source can retire its valid before it is sampled again.
   always_comb begin
      grant_fwd   = 1'b0;
      grant_local = 1'b0;
      if (state_q == S_IDLE && !(fwd_ack_q || local_ack_q)) begin
         if (fwd_valid && local_valid) begin
            if (starve_q == STARVE_LIM) begin
               grant_local = 1'b1;
            end else begin
               grant_fwd = 1'b1;
            end
         end else begin
            grant_local = local_valid;
            grant_fwd   = fwd_valid;
         end
      end
   end

   // Target ports: local traffic and upstream forwards share one mask.
   always_comb begin
      grant_mask = enable_piso_upstream;
      if (grant_fwd && fwd_downstream) begin
         grant_mask = enable_piso_downstream;
      end
   end

   // Starvation counter: counts forward wins over a waiting local packet.
   always_comb begin
      starve_d = starve_q;
      if (!local_valid || grant_local) begin
         starve_d = '0;
      end else if (grant_fwd && starve_q != STARVE_LIM) begin
         starve_d = starve_q + 1'b1;
      end
   end

   // Next-state logic for the grant / wait / load / confirm sequence.
   always_comb begin
      state_d     = state_q;
      mask_d      = mask_q;
      data_d      = data_q;
      fwd_ack_d   = grant_fwd;
      local_ack_d = grant_local;
      timer_d     = timer_q;
      drop_d      = drop_q;
      tout_d      = tout_q;
      unique case (state_q)
         S_IDLE: begin
            if (grant_fwd || grant_local) begin
               mask_d = grant_mask;
               data_d = grant_fwd ? fwd_data : local_data;
               if (grant_mask == 4'b0000) begin
                  if (drop_q != 16'hFFFF) begin
                     drop_d = drop_q + 16'd1;
                  end
               end else begin
                  state_d = S_WAIT_PORTS;
               end
            end
         end
         S_WAIT_PORTS: begin
            if ((tx_busy & mask_q) == 4'b0000) begin
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            timer_d = '0;
            state_d = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if ((tx_busy & mask_q) == mask_q) begin
               state_d = S_IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
               if (timer_d == TIMER_LIM) begin
                  if (tout_q != 8'hFF) begin
                     tout_d = tout_q + 8'd1;
                  end
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset drops any in-flight packet.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         mask_q      <= '0;
         data_q      <= '0;
         fwd_ack_q   <= 1'b0;
         local_ack_q <= 1'b0;
         starve_q    <= '0;
         timer_q     <= '0;
         drop_q      <= '0;
         tout_q      <= '0;
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         data_q      <= data_d;
         fwd_ack_q   <= fwd_ack_d;
         local_ack_q <= local_ack_d;
         starve_q    <= starve_d;
         timer_q     <= timer_d;
         drop_q      <= drop_d;
         tout_q      <= tout_d;
      end
   end

   assign fwd_ack         = fwd_ack_q;
   assign local_ack       = local_ack_q;
   assign ld_tx_data_uart = (state_q == S_LOAD) ? mask_q : 4'b0000;
   assign tx_data         = data_q;
   assign sched_busy      = (state_q != S_IDLE);
   assign drop_count      = drop_q;
   assign timeout_count   = tout_q;

endmodule

// File: tb/tb_hydra_tx_scheduler.sv
// tb_hydra_tx_scheduler: scenario tasks with a queue of expected loads
// filled at grant time and drained when the load pulse appears.
module tb_hydra_tx_scheduler;

   localparam int WIDTH = 64;
   localparam int DW    = WIDTH - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          fwd_valid = 1'b0;
   logic [DW-1:0] fwd_data = '0;
   logic          fwd_downstream = 1'b0;
   logic          fwd_ack;
   logic          local_valid = 1'b0;
   logic [DW-1:0] local_data = '0;
   logic          local_ack;
   logic [3:0]    en_up = 4'b0000;
   logic [3:0]    en_dn = 4'b0000;
   logic [3:0]    manual_busy = 4'b0000;
   logic [3:0]    auto_busy;
   logic [3:0]    tx_busy;
   logic [3:0]    ld;
   logic [DW-1:0] tx_data;
   logic          sched_busy;
   logic [15:0]   drop_count;
   logic [7:0]    timeout_count;
   logic          uart_auto = 1'b0;
   logic [1:0]    bcnt [4];

   int passed = 0;
   int total  = 0;

   logic [DW-1:0] exp_q [$];
   logic [3:0]    mexp_q [$];
   logic [7:0]    src_q [$];

   hydra_tx_scheduler #(
      .WIDTH(WIDTH),
      .MAX_STARVE(4),
      .BUSY_TIMEOUT(3)
   ) dut (
      .clk(clk),
      .reset(reset),
      .fwd_valid(fwd_valid),
      .fwd_data(fwd_data),
      .fwd_downstream(fwd_downstream),
      .fwd_ack(fwd_ack),
      .local_valid(local_valid),
      .local_data(local_data),
      .local_ack(local_ack),
      .enable_piso_upstream(en_up),
      .enable_piso_downstream(en_dn),
      .tx_busy(tx_busy),
      .ld_tx_data_uart(ld),
      .tx_data(tx_data),
      .sched_busy(sched_busy),
      .drop_count(drop_count),
      .timeout_count(timeout_count)
   );

   always #5 clk = ~clk;

   // Simple UART model: busy rises the edge after a load, lasts 3 cycles.
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (reset) bcnt[i] <= 2'd0;
         else if (ld[i]) bcnt[i] <= 2'd3;
         else if (bcnt[i] != 2'd0) bcnt[i] <= bcnt[i] - 2'd1;
      end
   end

   assign auto_busy = {bcnt[3] != 2'd0, bcnt[2] != 2'd0,
                       bcnt[1] != 2'd0, bcnt[0] != 2'd0};
   assign tx_busy = manual_busy | (uart_auto ? auto_busy : 4'b0000);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      total++;
      if ({fwd_ack, local_ack, ld, sched_busy, drop_count, timeout_count} !== 31'd0)
         $display("FAIL reset_ctrl got ack=%b%b ld=%b busy=%b drop=%0d tout=%0d want all 0",
                  fwd_ack, local_ack, ld, sched_busy, drop_count, timeout_count);
      else passed++;
      total++;
      if (tx_data !== '0) $display("FAIL reset_data got %h want 0", tx_data);
      else passed++;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_local_basic();
      en_up = 4'b0011;
      local_data = 63'h1234;
      local_valid = 1'b1;
      exp_q.push_back(63'h1234);
      mexp_q.push_back(4'b0011);
      tick();
      total++;
      if ({fwd_ack, local_ack} !== 2'b01)
         $display("FAIL basic_ack got %b%b want 01", fwd_ack, local_ack);
      else passed++;
      local_valid = 1'b0;
      total++;
      if (ld !== 4'b0000) $display("FAIL basic_early_ld got %b want 0000", ld);
      else passed++;
      tick();
      total++;
      if (ld !== mexp_q[0]) $display("FAIL basic_ld got %b want %b", ld, mexp_q[0]);
      else passed++;
      total++;
      if (tx_data !== exp_q[0]) $display("FAIL basic_data got %h want %h", tx_data, exp_q[0]);
      else passed++;
      void'(exp_q.pop_front());
      void'(mexp_q.pop_front());
      manual_busy = 4'b0011;
      tick();
      tick();
      total++;
      if (sched_busy !== 1'b0) $display("FAIL basic_idle got %b want 0", sched_busy);
      else passed++;
      manual_busy = 4'b0000;
      tick();
   endtask

   task automatic test_starvation();
      int n;
      bit done;
      logic [7:0] got;
      n = 0;
      done = 0;
      en_up = 4'b0001;
      fwd_downstream = 1'b0;
      uart_auto = 1'b1;
      fwd_data = 63'h100;
      local_data = 63'h200;
      for (int g = 0; g < 10; g++) src_q.push_back((g % 5 == 4) ? "L" : "F");
      fwd_valid = 1'b1;
      local_valid = 1'b1;
      for (int c = 0; c < 600; c++) begin
         tick();
         if (fwd_ack || local_ack) begin
            got = fwd_ack ? "F" : "L";
            total++;
            if (fwd_ack && local_ack) $display("FAIL starve_both_ack got 11 want one");
            else if (src_q.size() == 0) $display("FAIL starve_extra_grant got %s want none", got);
            else if (got !== src_q[0])
               $display("FAIL starve_grant%0d got %s want %s", n, got, src_q[0]);
            else passed++;
            if (src_q.size() != 0) void'(src_q.pop_front());
            exp_q.push_back(fwd_ack ? fwd_data : local_data);
            mexp_q.push_back(4'b0001);
            if (fwd_ack) fwd_data = fwd_data + 63'd1;
            else local_data = local_data + 63'd1;
            n++;
            if (n == 10) begin
               fwd_valid = 1'b0;
               local_valid = 1'b0;
            end
         end
         if (ld != 4'b0000) begin
            total++;
            if (exp_q.size() == 0) $display("FAIL starve_unexpected_ld got %b want none", ld);
            else if (tx_data !== exp_q[0] || ld !== mexp_q[0])
               $display("FAIL starve_load got %h/%b want %h/%b", tx_data, ld, exp_q[0], mexp_q[0]);
            else passed++;
            if (exp_q.size() != 0) begin
               void'(exp_q.pop_front());
               void'(mexp_q.pop_front());
            end
         end
         if (n == 10 && exp_q.size() == 0 && !sched_busy) begin
            done = 1;
            break;
         end
      end
      total++;
      if (!done) $display("FAIL starve_timeout got %0d grants want 10", n);
      else passed++;
      fwd_valid = 1'b0;
      local_valid = 1'b0;
      src_q.delete();
      exp_q.delete();
      mexp_q.delete();
      repeat (5) tick();
      uart_auto = 1'b0;
   endtask

   task automatic test_drop();
      bit seen;
      seen = 0;
      en_dn = 4'b0000;
      en_up = 4'b1111;
      fwd_downstream = 1'b1;
      fwd_data = 63'h55;
      fwd_valid = 1'b1;
      tick();
      total++;
      if ({fwd_ack, local_ack} !== 2'b10)
         $display("FAIL drop_ack got %b%b want 10", fwd_ack, local_ack);
      else passed++;
      fwd_valid = 1'b0;
      total++;
      if (drop_count !== 16'd1) $display("FAIL drop_count got %0d want 1", drop_count);
      else passed++;
      total++;
      if (sched_busy !== 1'b0) $display("FAIL drop_idle got %b want 0", sched_busy);
      else passed++;
      repeat (6) begin
         tick();
         if (ld != 4'b0000) seen = 1;
      end
      total++;
      if (seen !== 1'b0) $display("FAIL drop_no_ld got pulse want none");
      else passed++;
      total++;
      if (drop_count !== 16'd1) $display("FAIL drop_count_hold got %0d want 1", drop_count);
      else passed++;
      fwd_downstream = 1'b0;
   endtask

   task automatic test_wait_ports();
      int ldcnt;
      bit found;
      ldcnt = 0;
      found = 0;
      en_up = 4'b0110;
      manual_busy = 4'b0100;
      local_data = 63'h0ABC;
      local_valid = 1'b1;
      exp_q.push_back(63'h0ABC);
      mexp_q.push_back(4'b0110);
      tick();
      total++;
      if (local_ack !== 1'b1) $display("FAIL wp_ack got %b want 1", local_ack);
      else passed++;
      local_valid = 1'b0;
      repeat (10) begin
         tick();
         if (ld != 4'b0000) ldcnt++;
      end
      total++;
      if (ldcnt !== 0) $display("FAIL wp_blocked got %0d pulses want 0", ldcnt);
      else passed++;
      manual_busy = 4'b0000;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (ld != 4'b0000) begin
            found = 1;
            break;
         end
      end
      total++;
      if (!found) $display("FAIL wp_ld_timeout got none want %b", mexp_q[0]);
      else if (ld !== mexp_q[0] || tx_data !== exp_q[0])
         $display("FAIL wp_load got %h/%b want %h/%b", tx_data, ld, exp_q[0], mexp_q[0]);
      else passed++;
      void'(exp_q.pop_front());
      void'(mexp_q.pop_front());
      manual_busy = 4'b0110;
      tick();
      total++;
      if (ld !== 4'b0000) $display("FAIL wp_single_pulse got %b want 0000", ld);
      else passed++;
      tick();
      total++;
      if (sched_busy !== 1'b0) $display("FAIL wp_idle got %b want 0", sched_busy);
      else passed++;
      manual_busy = 4'b0000;
      tick();
   endtask

   task automatic test_timeout();
      int w;
      bit ok;
      en_up = 4'b0001;
      local_data = 63'h0F0F;
      local_valid = 1'b1;
      tick();
      local_valid = 1'b0;
      tick();
      total++;
      if (ld !== 4'b0001) $display("FAIL to_ld got %b want 0001", ld);
      else passed++;
      w = 0;
      while (sched_busy && w < 20) begin
         tick();
         w++;
      end
      total++;
      if (w !== 4) $display("FAIL to_latency got %0d edges want 4", w);
      else passed++;
      total++;
      if (timeout_count !== 8'd1) $display("FAIL to_count got %0d want 1", timeout_count);
      else passed++;
      ok = 1;
      for (int k = 2; k <= 256 && ok; k++) begin
         local_valid = 1'b1;
         w = 0;
         do begin
            tick();
            w++;
         end while (!local_ack && w < 10);
         local_valid = 1'b0;
         if (!local_ack) ok = 0;
         w = 0;
         while (sched_busy && w < 20) begin
            tick();
            w++;
         end
         if (sched_busy) ok = 0;
         if (k == 255) begin
            total++;
            if (timeout_count !== 8'd255) $display("FAIL to_count255 got %0d want 255", timeout_count);
            else passed++;
         end
      end
      total++;
      if (!ok) $display("FAIL to_loop_timeout got stuck want 256 timeouts");
      else passed++;
      total++;
      if (timeout_count !== 8'd255) $display("FAIL to_saturate got %0d want 255", timeout_count);
      else passed++;
      tick();
   endtask

   task automatic test_reset_midflight();
      en_up = 4'b0001;
      manual_busy = 4'b0001;
      local_data = 63'h77;
      local_valid = 1'b1;
      tick();
      local_valid = 1'b0;
      tick();
      total++;
      if ({sched_busy, ld} !== 5'b10000) $display("FAIL rst_waitports got %b%b want 10000", sched_busy, ld);
      else passed++;
      reset = 1'b1;
      #1;
      total++;
      if ({fwd_ack, local_ack, ld, sched_busy, drop_count, timeout_count} !== 31'd0 || tx_data !== '0)
         $display("FAIL rst_async got busy=%b ld=%b drop=%0d tout=%0d data=%h want all 0",
                  sched_busy, ld, drop_count, timeout_count, tx_data);
      else passed++;
      tick();
      reset = 1'b0;
      manual_busy = 4'b0000;
      tick();
      en_up = 4'b1000;
      local_data = 63'h4321;
      local_valid = 1'b1;
      exp_q.push_back(63'h4321);
      mexp_q.push_back(4'b1000);
      tick();
      total++;
      if ({fwd_ack, local_ack} !== 2'b01) $display("FAIL rst_new_ack got %b%b want 01", fwd_ack, local_ack);
      else passed++;
      local_valid = 1'b0;
      tick();
      total++;
      if (ld !== mexp_q[0] || tx_data !== exp_q[0])
         $display("FAIL rst_new_load got %h/%b want %h/%b", tx_data, ld, exp_q[0], mexp_q[0]);
      else passed++;
      void'(exp_q.pop_front());
      void'(mexp_q.pop_front());
      manual_busy = 4'b1000;
      tick();
      tick();
      total++;
      if (sched_busy !== 1'b0) $display("FAIL rst_new_idle got %b want 0", sched_busy);
      else passed++;
      manual_busy = 4'b0000;
      tick();
   endtask

   initial begin
      test_reset();
      test_local_basic();
      test_starvation();
      test_drop();
      test_wait_ports();
      test_timeout();
      test_reset_midflight();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
